// File: rtl/ddr_timing_tracker.sv
// ddr_timing_tracker
// Per-bank DDR timing-constraint tracker. It watches the command stream from the
// scheduler and keeps down-counters for every programmed timing constraint, along
// with the open-bank state, a four-slot tFAW window and refresh postponement.
// From that registered state it derives per-bank and rank-wide legality bitmaps.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   t_rcd..t_ccd (CNT_W)         short timing values in clocks, sampled at load
//   t_refi, t_rfc (REF_W)        refresh interval / refresh cycle time
//   cmd_valid/cmd_type/cmd_bank  issued command (0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 REF,6 PREA)
//   act_ok/rd_ok/wr_ok/pre_ok    per-bank legality for the current cycle
//   ref_ok, prea_ok              rank-wide legality
//   bank_open                    open-row state per bank
//   refresh_req/refresh_urgent   pending refresh != 0 / pending == MAX_POSTPONE
//   cmd_err                      one-cycle pulse for an illegal or reserved command
module ddr_timing_tracker #(
    parameter int NUM_BANKS    = 8,
    parameter int BANK_W       = $clog2(NUM_BANKS),
    parameter int CNT_W        = 8,
    parameter int REF_W        = 16,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     t_rcd,
    input  logic [CNT_W-1:0]     t_rp,
    input  logic [CNT_W-1:0]     t_ras,
    input  logic [CNT_W-1:0]     t_rc,
    input  logic [CNT_W-1:0]     t_wr,
    input  logic [CNT_W-1:0]     t_rrd,
    input  logic [CNT_W-1:0]     t_faw,
    input  logic [CNT_W-1:0]     t_wtr,
    input  logic [CNT_W-1:0]     t_ccd,
    input  logic [REF_W-1:0]     t_refi,
    input  logic [REF_W-1:0]     t_rfc,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd_type,
    input  logic [BANK_W-1:0]    cmd_bank,
    output logic [NUM_BANKS-1:0] act_ok,
    output logic [NUM_BANKS-1:0] rd_ok,
    output logic [NUM_BANKS-1:0] wr_ok,
    output logic [NUM_BANKS-1:0] pre_ok,
    output logic                 ref_ok,
    output logic                 prea_ok,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 refresh_req,
    output logic                 refresh_urgent,
    output logic                 cmd_err
);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_REF  = 3'd5;
    localparam logic [2:0] CMD_PREA = 3'd6;
    localparam logic [3:0] PEND_MAX = 4'(MAX_POSTPONE);

    logic [CNT_W-1:0] rcd_cnt [NUM_BANKS];
    logic [CNT_W-1:0] ras_cnt [NUM_BANKS];
    logic [CNT_W-1:0] rc_cnt  [NUM_BANKS];
    logic [CNT_W-1:0] rp_cnt  [NUM_BANKS];
    logic [CNT_W-1:0] wr_cnt  [NUM_BANKS];
    logic [CNT_W-1:0] faw_cnt [4];
    logic [CNT_W-1:0] rrd_cnt, wtr_cnt, ccd_cnt;
    logic [REF_W-1:0] refi_cnt, rfc_cnt;
    logic [3:0]       pending;
    // Low for the first cycle after reset so the refi counter gets its initial load
    // instead of being treated as an expiry.
    logic             started;

    logic [NUM_BANKS-1:0] bank_sel;
    logic [NUM_BANKS-1:0] rp_busy;
    logic [3:0]           faw_pick;
    logic                 cmd_legal;
    logic                 acc_act, acc_wr, acc_pre, acc_prea, acc_ref, refi_expire;

    // A constraint of T clocks loads T-1 so the dependent command is legal at N+T.
    function automatic logic [CNT_W-1:0] cnt_load(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

    function automatic logic [REF_W-1:0] ref_load(input logic [REF_W-1:0] t);
        return (t == '0) ? '0 : t - REF_W'(1);
    endfunction

    function automatic logic [REF_W-1:0] ref_dec(input logic [REF_W-1:0] c);
        return (c == '0) ? '0 : c - REF_W'(1);
    endfunction

    // Legality depends only on registered state; cmd_* never reaches these outputs.
    always_comb begin
        faw_pick = '0;
        // Scan high to low so the lowest-index free slot is the one that wins.
        for (int i = 3; i >= 0; i--) begin
            if (faw_cnt[i] == '0) faw_pick = 4'b0001 << i;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            rp_busy[b] = (rp_cnt[b] != '0);
            act_ok[b]  = !bank_open[b] && (rc_cnt[b] == '0) && (rp_cnt[b] == '0) &&
                         (rrd_cnt == '0) && (rfc_cnt == '0) && (faw_pick != '0);
            rd_ok[b]   = bank_open[b] && (rcd_cnt[b] == '0) && (ccd_cnt == '0) &&
                         (wtr_cnt == '0);
            wr_ok[b]   = bank_open[b] && (rcd_cnt[b] == '0) && (ccd_cnt == '0);
            pre_ok[b]  = bank_open[b] && (ras_cnt[b] == '0) && (wr_cnt[b] == '0);
        end
        prea_ok        = &(~bank_open | pre_ok);
        ref_ok         = (bank_open == '0) && (rp_busy == '0) && (rfc_cnt == '0);
        refresh_req    = (pending != '0);
        refresh_urgent = (pending == PEND_MAX);
    end

    always_comb begin
        bank_sel = NUM_BANKS'(1) << cmd_bank;
        case (cmd_type)
            CMD_NOP:  cmd_legal = 1'b1;
            CMD_ACT:  cmd_legal = act_ok[cmd_bank];
            CMD_RD:   cmd_legal = rd_ok[cmd_bank];
            CMD_WR:   cmd_legal = wr_ok[cmd_bank];
            CMD_PRE:  cmd_legal = pre_ok[cmd_bank];
            CMD_REF:  cmd_legal = ref_ok;
            CMD_PREA: cmd_legal = prea_ok;
            default:  cmd_legal = 1'b0;
        endcase
        acc_act     = cmd_valid && cmd_legal && (cmd_type == CMD_ACT);
        acc_wr      = cmd_valid && cmd_legal && (cmd_type == CMD_WR);
        acc_pre     = cmd_valid && cmd_legal && (cmd_type == CMD_PRE);
        acc_prea    = cmd_valid && cmd_legal && (cmd_type == CMD_PREA);
        acc_ref     = cmd_valid && cmd_legal && (cmd_type == CMD_REF);
        refi_expire = started && (refi_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_cnt[b] <= '0;
                ras_cnt[b] <= '0;
                rc_cnt[b]  <= '0;
                rp_cnt[b]  <= '0;
                wr_cnt[b]  <= '0;
            end
            for (int i = 0; i < 4; i++) faw_cnt[i] <= '0;
            rrd_cnt   <= '0;
            wtr_cnt   <= '0;
            ccd_cnt   <= '0;
            refi_cnt  <= '0;
            rfc_cnt   <= '0;
            pending   <= '0;
            started   <= 1'b0;
            bank_open <= '0;
            cmd_err   <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_cnt[b] <= (acc_act && bank_sel[b]) ? cnt_load(t_rcd) : cnt_dec(rcd_cnt[b]);
                ras_cnt[b] <= (acc_act && bank_sel[b]) ? cnt_load(t_ras) : cnt_dec(ras_cnt[b]);
                rc_cnt[b]  <= (acc_act && bank_sel[b]) ? cnt_load(t_rc)  : cnt_dec(rc_cnt[b]);
                wr_cnt[b]  <= (acc_wr  && bank_sel[b]) ? cnt_load(t_wr)  : cnt_dec(wr_cnt[b]);
                // PREA only starts tRP on banks that were actually open.
                rp_cnt[b]  <= ((acc_pre && bank_sel[b]) || (acc_prea && bank_open[b])) ?
                              cnt_load(t_rp) : cnt_dec(rp_cnt[b]);
                if (acc_act && bank_sel[b]) begin
                    bank_open[b] <= 1'b1;
                end else if ((acc_pre && bank_sel[b]) || acc_prea) begin
                    bank_open[b] <= 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                faw_cnt[i] <= (acc_act && faw_pick[i]) ? cnt_load(t_faw) : cnt_dec(faw_cnt[i]);
            end
            rrd_cnt <= acc_act ? cnt_load(t_rrd) : cnt_dec(rrd_cnt);
            wtr_cnt <= acc_wr  ? cnt_load(t_wtr) : cnt_dec(wtr_cnt);
            ccd_cnt <= (acc_wr || (cmd_valid && cmd_legal && cmd_type == CMD_RD)) ?
                       cnt_load(t_ccd) : cnt_dec(ccd_cnt);
            rfc_cnt <= acc_ref ? ref_load(t_rfc) : ref_dec(rfc_cnt);

            started  <= 1'b1;
            refi_cnt <= (!started || refi_cnt == '0) ? ref_load(t_refi) : ref_dec(refi_cnt);
            // Expiry and a legal REF together cancel out.
            if (refi_expire && !acc_ref) begin
                if (pending != PEND_MAX) pending <= pending + 4'd1;
            end else if (acc_ref && !refi_expire) begin
                if (pending != '0) pending <= pending - 4'd1;
            end

            cmd_err <= cmd_valid && !cmd_legal;
        end
    end

endmodule

// File: tb/tb_ddr_timing_tracker.sv
// Testbench for ddr_timing_tracker: directed scenarios with hand-derived expectations.
// Each driven cycle pushes the expected cmd_err into a scoreboard queue, and that
// entry is popped and compared once the DUT has registered the command.
module tb_ddr_timing_tracker;

    localparam int NB     = 8;
    localparam int BANK_W = 3;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3;
    localparam logic [2:0] PRE = 3'd4, REFC = 3'd5, PREA = 3'd6, RSV = 3'd7;

    logic clk, reset;
    logic [7:0]  t_rcd, t_rp, t_ras, t_rc, t_wr, t_rrd, t_faw, t_wtr, t_ccd;
    logic [15:0] t_refi, t_rfc;
    logic cmd_valid;
    logic [2:0] cmd_type;
    logic [BANK_W-1:0] cmd_bank;
    logic [NB-1:0] act_ok, rd_ok, wr_ok, pre_ok, bank_open;
    logic ref_ok, prea_ok, refresh_req, refresh_urgent, cmd_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic  err_q [$];
    string tag_q [$];

    ddr_timing_tracker #(.NUM_BANKS(NB), .MAX_POSTPONE(2)) dut (
        .clk(clk), .reset(reset),
        .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rc(t_rc), .t_wr(t_wr),
        .t_rrd(t_rrd), .t_faw(t_faw), .t_wtr(t_wtr), .t_ccd(t_ccd),
        .t_refi(t_refi), .t_rfc(t_rfc),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
        .act_ok(act_ok), .rd_ok(rd_ok), .wr_ok(wr_ok), .pre_ok(pre_ok),
        .ref_ok(ref_ok), .prea_ok(prea_ok), .bank_open(bank_open),
        .refresh_req(refresh_req), .refresh_urgent(refresh_urgent), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then compare the cmd_err expected for the command just sampled.
    task automatic tick();
        logic  e;
        string t;
        @(posedge clk);
        #1;
        if (err_q.size() != 0) begin
            e = err_q.pop_front();
            t = tag_q.pop_front();
            check(t, {31'd0, cmd_err}, {31'd0, e});
        end
        cmd_valid = 1'b0;
        cmd_type  = NOP;
    endtask

    task automatic issue(input logic [2:0] ty, input int b, input logic exp_err, input string tag);
        cmd_valid = 1'b1;
        cmd_type  = ty;
        cmd_bank  = BANK_W'(b);
        err_q.push_back(exp_err);
        tag_q.push_back(tag);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            err_q.push_back(1'b0);
            tag_q.push_back("idle_err");
            tick();
        end
    endtask

    task automatic set_defaults();
        t_rcd = 8'd1; t_rp = 8'd1; t_ras = 8'd1; t_rc = 8'd1; t_wr = 8'd1;
        t_rrd = 8'd1; t_faw = 8'd1; t_wtr = 8'd1; t_ccd = 8'd1;
        t_refi = 16'd100; t_rfc = 16'd10;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_type = NOP;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_type = NOP; cmd_bank = '0;
        set_defaults();
        do_reset();

        // Reset state
        check("rst_act_ok",  act_ok, 32'hFF);
        check("rst_pre_ok",  pre_ok, 0);
        check("rst_rd_ok",   rd_ok, 0);
        check("rst_wr_ok",   wr_ok, 0);
        check("rst_ref_ok",  ref_ok, 1);
        check("rst_prea_ok", prea_ok, 1);
        check("rst_open",    bank_open, 0);
        check("rst_req",     refresh_req, 0);
        check("rst_urgent",  refresh_urgent, 0);
        check("rst_err",     cmd_err, 0);

        // tRCD gating and an early RD that must not load tCCD
        t_rcd = 8'd4; t_ccd = 8'd8;
        check("s1_rd_c0", rd_ok[2], 0);
        issue(ACT, 2, 1'b0, "s1_act");
        check("s1_rd_c1", rd_ok[2], 0);
        idle(1);
        check("s1_rd_c2", rd_ok[2], 0);
        issue(RD, 2, 1'b1, "s1_rd_early");
        check("s1_rd_c3", rd_ok[2], 0);
        idle(1);
        check("s1_rd_c4", rd_ok[2], 1);
        check("s1_wr_c4", wr_ok[2], 1);
        issue(RD, 2, 1'b0, "s1_rd_ok");
        check("s1_ccd_block", rd_ok[2], 0);
        check("s1_open", bank_open, 32'h04);

        // tRRD and the four-activate window
        set_defaults();
        do_reset();
        t_rrd = 8'd2; t_faw = 8'd20;
        for (int c = 0; c <= 6; c++) begin
            if (c % 2 == 0) issue(ACT, c / 2, 1'b0, "s2_act");
            else begin
                check("s2_rrd", act_ok, 0);
                idle(1);
            end
        end
        for (int c = 7; c <= 19; c++) begin
            check("s2_faw_block", act_ok, 0);
            if (c == 12) issue(ACT, 5, 1'b1, "s2_act_faw_err");
            else idle(1);
        end
        check("s2_open_before", bank_open, 32'h0F);
        check("s2_faw_free", act_ok, 32'hF0);
        issue(ACT, 4, 1'b0, "s2_act4");
        check("s2_open_after", bank_open, 32'h1F);

        // tWR/tRAS before PRE, then tRP and tRC before the next ACT
        set_defaults();
        do_reset();
        t_wr = 8'd6; t_ras = 8'd3; t_rcd = 8'd2; t_rp = 8'd3; t_rc = 8'd16;
        issue(ACT, 1, 1'b0, "s3_act");
        idle(3);
        check("s3_pre_ras_done", pre_ok[1], 1);
        idle(1);
        issue(WR, 1, 1'b0, "s3_wr");
        for (int c = 6; c <= 10; c++) begin
            check("s3_pre_wr_block", pre_ok[1], 0);
            if (c == 8) issue(PRE, 1, 1'b1, "s3_pre_early");
            else idle(1);
        end
        check("s3_pre_ok", pre_ok[1], 1);
        issue(PRE, 1, 1'b0, "s3_pre");
        check("s3_closed", bank_open[1], 0);
        for (int c = 12; c <= 15; c++) begin
            check("s3_act_block", act_ok[1], 0);
            idle(1);
        end
        check("s3_act_back", act_ok[1], 1);

        // tCCD dominating tWTR, then tWTR alone
        set_defaults();
        do_reset();
        t_wtr = 8'd3; t_ccd = 8'd4;
        issue(RSV, 0, 1'b1, "s4_reserved");
        issue(ACT, 0, 1'b0, "s4_act");
        issue(WR, 0, 1'b0, "s4_wr");
        check("s4_rd_w1", rd_ok[0], 0);
        idle(1);
        check("s4_rd_w2", rd_ok[0], 0);
        idle(1);
        check("s4_rd_w3", rd_ok[0], 0);
        check("s4_wr_w3", wr_ok[0], 0);
        issue(RD, 0, 1'b1, "s4_rd_early");
        check("s4_rd_w4", rd_ok[0], 1);
        issue(RD, 0, 1'b0, "s4_rd");
        idle(3);
        t_ccd = 8'd1;
        issue(WR, 0, 1'b0, "s4_wr2");
        check("s4_wtr_rd", rd_ok[0], 0);
        check("s4_wtr_wr", wr_ok[0], 1);
        idle(1);
        check("s4_wtr_rd2", rd_ok[0], 0);
        idle(1);
        check("s4_wtr_rd3", rd_ok[0], 1);

        // Refresh postponement with MAX_POSTPONE=2 and tREFI=100
        set_defaults();
        do_reset();
        idle(100);
        check("s5_req_pre", refresh_req, 0);
        idle(1);
        check("s5_req", refresh_req, 1);
        check("s5_urg_pre", refresh_urgent, 0);
        idle(99);
        check("s5_urg_pre2", refresh_urgent, 0);
        idle(1);
        check("s5_urgent", refresh_urgent, 1);
        idle(100);
        check("s5_sat_req", refresh_req, 1);
        check("s5_sat_urg", refresh_urgent, 1);
        issue(ACT, 3, 1'b0, "s5_act");
        check("s5_ref_blocked", ref_ok, 0);
        issue(REFC, 0, 1'b1, "s5_ref_err");
        check("s5_prea_ok", prea_ok, 1);
        issue(PREA, 0, 1'b0, "s5_prea");
        check("s5_open", bank_open, 0);
        check("s5_ref_ok", ref_ok, 1);
        issue(REFC, 0, 1'b0, "s5_ref");
        check("s5_req_after", refresh_req, 1);
        check("s5_urg_after", refresh_urgent, 0);
        for (int j = 0; j <= 8; j++) begin
            check("s5_rfc_ref", ref_ok, 0);
            check("s5_rfc_act", act_ok, 0);
            idle(1);
        end
        check("s5_rfc_done", ref_ok, 1);

        // Reset mid-operation
        issue(ACT, 0, 1'b0, "s6_act0");
        issue(ACT, 1, 1'b0, "s6_act1");
        issue(ACT, 2, 1'b0, "s6_act2");
        check("s6_open", bank_open, 32'h07);
        check("s6_req", refresh_req, 1);
        reset = 1'b1;
        issue(RD, 5, 1'b0, "s6_err_masked");
        reset = 1'b0;
        check("s6_open_rst", bank_open, 0);
        check("s6_req_rst", refresh_req, 0);
        check("s6_act_rst", act_ok, 32'hFF);
        check("s6_pre_rst", pre_ok, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_timing_tracker.md
Name: ddr_timing_tracker

Overview:
- Parametrised per-bank DDR timing-constraint tracker; successor to the static timing-parameter block.
- Consumes programmed timing values and the command stream issued by the scheduler.
- Maintains per-bank and rank-wide countdown counters, open-bank state, a tFAW window and refresh postponement.
- Outputs per-bank legality bitmaps the scheduler must honour. An illegal command is rejected and flagged.

Parameters:
NUM_BANKS, 8, number of banks tracked (power of 2, >=2)
BANK_W, $clog2(NUM_BANKS), bank index width
CNT_W, 8, width of short timing counters (tRCD, tRP, tRAS, tRC, tRRD, tFAW, tWTR, tWR, tCCD)
REF_W, 16, width of tREFI/tRFC counters
MAX_POSTPONE, 8, maximum pending refreshes (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
t_rcd, t_rp, t_ras, t_rc, t_wr  in  CNT_W each  timing values in clocks
t_rrd, t_faw, t_wtr, t_ccd  in  CNT_W each  timing values in clocks
t_refi, t_rfc  in  REF_W each  refresh interval / refresh cycle time
cmd_valid  in  1  command issued this cycle
cmd_type  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 PREA, 7 reserved
cmd_bank  in  BANK_W  target bank (ignored for REF/PREA)
act_ok, rd_ok, wr_ok, pre_ok  out  NUM_BANKS  per-bank legality this cycle
ref_ok, prea_ok  out  1  rank-wide legality
bank_open  out  NUM_BANKS  open-row state
refresh_req  out  1  pending refresh count != 0
refresh_urgent  out  1  pending == MAX_POSTPONE
cmd_err  out  1  one-cycle pulse: previous command illegal or reserved

Behaviour:
Reset:
- All counters 0, bank_open 0, pending 0, cmd_err 0.
- refi counter loads t_refi-1 on the first cycle after reset deasserts.
- Outputs follow from counter state: act_ok all 1, pre_ok 0, rd_ok/wr_ok 0, ref_ok 1, prea_ok 1.

Timing rule:
- A command accepted in cycle N with constraint T loads its counter with max(T-1,0).
- Counters decrement by 1 per cycle, saturating at 0. A constraint is met when the counter reads 0.
- Result: the dependent command is legal exactly at cycle N+T. T=0 or T=1 both mean legal at N+1.
- Timing inputs are sampled only at load time. Changing them never alters running counters.
- All *_ok outputs are combinational from registered state only, with no path from cmd_* inputs.

Per-command rules (legal condition -> state update):
- ACT b:
  - legal when bank b closed, rc[b]=0, rp[b]=0, rrd=0, rfc=0, and at least one of 4 faw slots is 0.
  - update: open b; rcd[b]<-t_rcd, ras[b]<-t_ras, rc[b]<-t_rc, rrd<-t_rrd; the lowest-index zero faw slot <-t_faw.
- RD b:
  - legal when bank b open, rcd[b]=0, ccd=0, wtr=0.
  - update: ccd<-t_ccd.
- WR b:
  - legal when bank b open, rcd[b]=0, ccd=0.
  - update: ccd<-t_ccd, wtr<-t_wtr, wr[b]<-t_wr.
- PRE b:
  - legal when bank b open, ras[b]=0, wr[b]=0.
  - update: close b, rp[b]<-t_rp.
- PREA:
  - legal when every open bank meets the PRE condition. PREA with no banks open is legal and a no-op for rp.
  - update: close all banks; rp[b]<-t_rp for every bank that was open.
- REF:
  - legal when no bank open, all rp=0, rfc=0.
  - update: rfc<-t_rfc; pending decrements (floor 0).
- NOP or cmd_valid=0: no update.
- Illegal or reserved command: no state update; cmd_err=1 in cycle N+1 only.

Refresh:
- refi counter decrements each cycle. At 0 it reloads t_refi-1 and pending increments, saturating at MAX_POSTPONE.
- Expiry and a legal REF in the same cycle leave pending unchanged.
- refresh_urgent does not block other commands; the scheduler enforces it.

Reset mid-operation: a synchronous reset at any cycle restores all reset values in the next cycle, including discarding open banks and pending refreshes.

Test Plan:
1. t_rcd=4: ACT bank 2 at cycle 10 -> rd_ok[2]=0 cycles 10..13, 1 at cycle 14; RD to bank 2 at cycle 12 -> cmd_err=1 at 13, no ccd load.
2. t_rrd=2, t_faw=20: ACT banks 0,1,2,3 at cycles 0,2,4,6 -> act_ok=0 for every closed bank from cycle 7 until cycle 20; ACT bank 4 at cycle 20 accepted.
3. t_wr=6, t_ras=3: ACT b1 at 0, WR b1 at 5 -> pre_ok[1]=0 until cycle 11, 1 at 11; PRE accepted at 11; act_ok[1] returns once rp and rc both reach 0.
4. t_wtr=3, t_ccd=4: WR b0 at cycle 20 -> rd_ok[0]=0 until cycle 24 (ccd dominates), RD at 24 accepted.
5. t_refi=100, MAX_POSTPONE=2, no REF issued -> refresh_req at cycle 100, refresh_urgent at cycle 200, pending saturates at 2 at cycle 300; PREA then REF -> pending 1, ref_ok=0 for t_rfc cycles.
6. reset asserted with 3 banks open and pending=1 -> next cycle bank_open=0, refresh_req=0, act_ok all 1, cmd_err=0.
